db_multi: RTL and testbench

- Parametrised multi-channel button conditioner, clocked on slow_clk; generalises the single-channel DFF-chain debouncer.
- Per channel:
  - synchroniser on the raw input
  - counter-based stability filter with configurable depth
  - registered level output
  - one-cycle press and release pulses
  - optional auto-repeat of the press pulse while held
- Sits between the board buttons and the control FSMs, which consume only pulses.

---
 rtl/db_multi_if.sv | 21 ++
 rtl/db_multi.sv | 134 +++++++++++++
 tb/tb_db_multi.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/db_multi_if.sv
// Button conditioner bus: raw inputs and repeat enable in, debounced level and pulses out.
interface db_multi_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0] sig_in;
   logic            rpt_en;
   logic [N_CH-1:0] btn_level;
   logic [N_CH-1:0] btn_press;
   logic [N_CH-1:0] btn_release;
   logic            any_press;

   modport master (
      output sig_in, rpt_en,
      input  btn_level, btn_press, btn_release, any_press
   );

   modport slave (
      input  sig_in, rpt_en,
      output btn_level, btn_press, btn_release, any_press
   );
endinterface

// File: rtl/db_multi.sv
// Multi-channel button conditioner: synchroniser, counter debounce, press/release pulses
// and optional auto-repeat of the press pulse while a button is held.
module db_multi #(
   parameter int N_CH         = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int STABLE_CNT   = 4,
   parameter int ACTIVE_LOW   = 0,
   parameter int REPEAT_DELAY = 250,
   parameter int REPEAT_RATE  = 50
) (
   input logic       slow_clk,
   input logic       rst_n,
   db_multi_if.slave bus
);

   localparam int CNT_W = $clog2(STABLE_CNT + 1);
   localparam int MAX_R = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RC_W  = (MAX_R > 1) ? $clog2(MAX_R) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
   localparam logic [RC_W-1:0]  RD_LAST  = RC_W'(REPEAT_DELAY - 1);
   localparam logic [RC_W-1:0]  RR_LAST  = RC_W'(REPEAT_RATE - 1);
   localparam logic             POL      = (ACTIVE_LOW != 0);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
   localparam logic [1:0] RPT  = 2'd2;

   logic [N_CH-1:0]        x_in;
   logic [SYNC_STAGES-1:0] sync_p0 [N_CH];
   logic [SYNC_STAGES-1:0] sync_d  [N_CH];
   logic [CNT_W-1:0]       cnt_p1  [N_CH];
   logic [CNT_W-1:0]       cnt_d   [N_CH];
   logic [1:0]             st_p1   [N_CH];
   logic [1:0]             st_d    [N_CH];
   logic [RC_W-1:0]        rc_p1   [N_CH];
   logic [RC_W-1:0]        rc_d    [N_CH];
   logic [N_CH-1:0]        level_p1, level_d;
   logic [N_CH-1:0]        press_p1, press_d;
   logic [N_CH-1:0]        rel_p1,   rel_d;

   assign x_in = bus.sig_in ^ {N_CH{POL}};

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         sync_d[i]   = {sync_p0[i][SYNC_STAGES-2:0], x_in[i]};
         cnt_d[i]    = '0;
         level_d[i]  = level_p1[i];
         st_d[i]     = st_p1[i];
         rc_d[i]     = rc_p1[i];
         press_d[i]  = 1'b0;
         rel_d[i]    = 1'b0;

         if (sync_p0[i][SYNC_STAGES-1] != level_p1[i]) begin
            if (cnt_p1[i] == CNT_LAST) level_d[i] = sync_p0[i][SYNC_STAGES-1];
            else                       cnt_d[i]   = cnt_p1[i] + 1'b1;
         end

         // A falling level always wins over a repeat pulse due on the same edge.
         rel_d[i] = level_p1[i] & ~level_d[i];

         case (st_p1[i])
            IDLE: begin
               if (level_d[i] & ~level_p1[i]) begin
                  st_d[i]    = HOLD;
                  rc_d[i]    = '0;
                  press_d[i] = 1'b1;
               end
            end
            HOLD: begin
               if (rel_d[i]) begin
                  st_d[i] = IDLE;
               end else if (!bus.rpt_en) begin
                  rc_d[i] = '0;
               end else if (rc_p1[i] == RD_LAST) begin
                  st_d[i]    = RPT;
                  rc_d[i]    = '0;
                  press_d[i] = 1'b1;
               end else begin
                  rc_d[i] = rc_p1[i] + 1'b1;
               end
            end
            RPT: begin
               if (rel_d[i]) begin
                  st_d[i] = IDLE;
               end else if (!bus.rpt_en) begin
                  st_d[i] = HOLD;
                  rc_d[i] = '0;
               end else if (rc_p1[i] == RR_LAST) begin
                  rc_d[i]    = '0;
                  press_d[i] = 1'b1;
               end else begin
                  rc_d[i] = rc_p1[i] + 1'b1;
               end
            end
            default: begin
               st_d[i] = IDLE;
               rc_d[i] = '0;
            end
         endcase
      end
   end

   // p0: synchroniser chain; p1: filter, repeat FSM and registered outputs
   always_ff @(posedge slow_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            sync_p0[i] <= '0;
            cnt_p1[i]  <= '0;
            st_p1[i]   <= IDLE;
            rc_p1[i]   <= '0;
         end
         level_p1 <= '0;
         press_p1 <= '0;
         rel_p1   <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            sync_p0[i] <= sync_d[i];
            cnt_p1[i]  <= cnt_d[i];
            st_p1[i]   <= st_d[i];
            rc_p1[i]   <= rc_d[i];
         end
         level_p1 <= level_d;
         press_p1 <= press_d;
         rel_p1   <= rel_d;
      end
   end

   assign bus.btn_level   = level_p1;
   assign bus.btn_press   = press_p1;
   assign bus.btn_release = rel_p1;
   assign bus.any_press   = |press_p1;

endmodule

// File: tb/tb_db_multi.sv
// Directed bench for db_multi: debounce latency, glitch/bounce rejection, pulses,
// auto-repeat timing, async reset and an active-low build.
module tb_db_multi;

   logic slow_clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   db_multi_if #(.N_CH(4)) bus ();
   db_multi_if #(.N_CH(4)) bus_al ();

   db_multi #(
      .N_CH(4), .SYNC_STAGES(2), .STABLE_CNT(3), .ACTIVE_LOW(0),
      .REPEAT_DELAY(8), .REPEAT_RATE(4)
   ) u_dut (
      .slow_clk (slow_clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   db_multi #(
      .N_CH(4), .SYNC_STAGES(2), .STABLE_CNT(3), .ACTIVE_LOW(1),
      .REPEAT_DELAY(8), .REPEAT_RATE(4)
   ) u_dut_al (
      .slow_clk (slow_clk),
      .rst_n    (rst_n),
      .bus      (bus_al)
   );

   initial slow_clk = 1'b0;
   always #5 slow_clk = ~slow_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                          input logic [3:0] rel);
      chk({tag, "_lvl"}, 32'(bus.btn_level), 32'(lvl));
      chk({tag, "_prs"}, 32'(bus.btn_press), 32'(prs));
      chk({tag, "_rel"}, 32'(bus.btn_release), 32'(rel));
      chk({tag, "_any"}, 32'(bus.any_press), 32'(|prs));
   endtask

   task automatic step(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                       input logic [3:0] rel);
      @(posedge slow_clk);
      #1;
      chk_all(tag, lvl, prs, rel);
   endtask

   task automatic run(input int n, input string tag, input logic [3:0] lvl,
                      input logic [3:0] prs, input logic [3:0] rel);
      for (int k = 0; k < n; k++) step(tag, lvl, prs, rel);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.sig_in    = 4'b0000;
      bus.rpt_en    = 1'b0;
      bus_al.sig_in = 4'b1111;
      bus_al.rpt_en = 1'b0;
      #2;
      chk_all("reset", 4'b0000, 4'b0000, 4'b0000);
      run(2, "rst_hold", 4'b0000, 4'b0000, 4'b0000);
      rst_n = 1'b1;
      run(3, "idle", 4'b0000, 4'b0000, 4'b0000);

      // Clean press on ch0, held 20 cycles, no repeat
      bus.sig_in = 4'b0001;
      run(4, "cp_wait", 4'b0000, 4'b0000, 4'b0000);
      step("cp_edge", 4'b0001, 4'b0001, 4'b0000);
      run(15, "cp_hold", 4'b0001, 4'b0000, 4'b0000);
      bus.sig_in = 4'b0000;
      run(4, "cr_wait", 4'b0001, 4'b0000, 4'b0000);
      step("cr_edge", 4'b0000, 4'b0000, 4'b0001);
      step("cr_after", 4'b0000, 4'b0000, 4'b0000);

      // Two-cycle glitch on ch1 must vanish
      bus.sig_in = 4'b0010;
      run(2, "gl_hi", 4'b0000, 4'b0000, 4'b0000);
      bus.sig_in = 4'b0000;
      run(8, "gl_lo", 4'b0000, 4'b0000, 4'b0000);

      // Bounce on ch2: 1,0,1,0 then holds 1
      for (int k = 0; k < 4; k++) begin
         bus.sig_in = (k % 2 == 0) ? 4'b0100 : 4'b0000;
         step("bn_tog", 4'b0000, 4'b0000, 4'b0000);
      end
      bus.sig_in = 4'b0100;
      run(4, "bn_wait", 4'b0000, 4'b0000, 4'b0000);
      step("bn_edge", 4'b0100, 4'b0100, 4'b0000);
      run(3, "bn_hold", 4'b0100, 4'b0000, 4'b0000);
      bus.sig_in = 4'b0000;
      run(4, "bn_rwait", 4'b0100, 4'b0000, 4'b0000);
      step("bn_rel", 4'b0000, 4'b0000, 4'b0100);

      // Channels 0 and 2 together
      bus.sig_in = 4'b0101;
      run(4, "mc_wait", 4'b0000, 4'b0000, 4'b0000);
      step("mc_edge", 4'b0101, 4'b0101, 4'b0000);
      step("mc_after", 4'b0101, 4'b0000, 4'b0000);
      bus.sig_in = 4'b0000;
      run(4, "mc_rwait", 4'b0101, 4'b0000, 4'b0000);
      step("mc_rel", 4'b0000, 4'b0000, 4'b0101);
      step("mc_idle", 4'b0000, 4'b0000, 4'b0000);

      // Auto-repeat on ch3: pulses at P, P+8, then every 4
      bus.rpt_en = 1'b1;
      bus.sig_in = 4'b1000;
      run(4, "ar_wait", 4'b0000, 4'b0000, 4'b0000);
      step("ar_P", 4'b1000, 4'b1000, 4'b0000);
      for (int k = 1; k <= 22; k++)
         step("ar_rpt", 4'b1000, (k == 8 || k == 12 || k == 16 || k == 20) ? 4'b1000 : 4'b0000,
              4'b0000);
      bus.rpt_en = 1'b0;
      run(6, "ar_off", 4'b1000, 4'b0000, 4'b0000);
      bus.rpt_en = 1'b1;
      for (int k = 1; k <= 10; k++)
         step("ar_reon", 4'b1000, (k == 8) ? 4'b1000 : 4'b0000, 4'b0000);

      // Asynchronous reset while repeating
      rst_n = 1'b0;
      #2;
      chk_all("async_rst", 4'b0000, 4'b0000, 4'b0000);
      run(2, "rst_mid", 4'b0000, 4'b0000, 4'b0000);
      rst_n = 1'b1;
      run(4, "fr_wait", 4'b0000, 4'b0000, 4'b0000);
      step("fr_press", 4'b1000, 4'b1000, 4'b0000);

      // Release lands on the edge a repeat is due: release only
      run(3, "pri_hold", 4'b1000, 4'b0000, 4'b0000);
      bus.sig_in = 4'b0000;
      run(4, "pri_wait", 4'b1000, 4'b0000, 4'b0000);
      step("pri_rel", 4'b0000, 4'b0000, 4'b1000);
      step("pri_after", 4'b0000, 4'b0000, 4'b0000);
      bus.rpt_en = 1'b0;

      // Active-low build: idle-high inputs read as released
      chk("al_idle_lvl", 32'(bus_al.btn_level), 32'(4'b0000));
      chk("al_idle_prs", 32'(bus_al.btn_press), 32'(4'b0000));
      bus_al.sig_in = 4'b1110;
      for (int k = 1; k <= 4; k++) begin
         @(posedge slow_clk);
         #1;
         chk("al_wait", 32'(bus_al.btn_level), 32'(4'b0000));
      end
      @(posedge slow_clk);
      #1;
      chk("al_edge_lvl", 32'(bus_al.btn_level), 32'(4'b0001));
      chk("al_edge_prs", 32'(bus_al.btn_press), 32'(4'b0001));
      chk("al_edge_any", 32'(bus_al.any_press), 32'(1'b1));
      @(posedge slow_clk);
      #1;
      chk("al_after_prs", 32'(bus_al.btn_press), 32'(4'b0000));
      chk("al_after_lvl", 32'(bus_al.btn_level), 32'(4'b0001));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
